// File: rtl/mmss_time_counter_if.sv
// Control and BCD digit bundle between the minute:second counter and its users.
// Pure wiring; no storage or added delay.
// No flow control: controls are levels or single-cycle pulses, outputs are registered levels.
interface mmss_time_counter_if;
   logic       Run_En;
   logic       Clr;
   logic       Inc_Sec;
   logic       Inc_Min;
   logic [3:0] SecL;
   logic [3:0] SecH;
   logic [3:0] MinL;
   logic [3:0] MinH;
   logic       Sec_Tick;
   logic       Hour_Carry;

   // Controller side: drives the controls and observes the digits.
   modport master (
      output Run_En, Clr, Inc_Sec, Inc_Min,
      input  SecL, SecH, MinL, MinH, Sec_Tick, Hour_Carry
   );

   // Counter side: consumes the controls and produces the digits.
   modport slave (
      input  Run_En, Clr, Inc_Sec, Inc_Min,
      output SecL, SecH, MinL, MinH, Sec_Tick, Hour_Carry
   );
endinterface

// File: rtl/mmss_time_counter.sv
// Prescaled 1 Hz timebase and BCD mm:ss counter with stop/run, clear and manual set.
// Digits and pulses update one CLK after the controlling inputs; all outputs are registered.
// No backpressure: Inc_* pulses are dropped while running, and stopping freezes the prescaler phase.
module mmss_time_counter #(
   parameter logic [25:0] DIV_MAX = 26'd49_999_999
) (
   input logic              CLK,
   input logic              RSTn,
   mmss_time_counter_if.slave bus
);

   logic [25:0] presc;
   logic [3:0]  sec_l, sec_h, min_l, min_h;
   logic        sec_tick, hour_carry;

   logic [3:0]  sec_l_nxt, sec_h_nxt, min_l_nxt, min_h_nxt;
   logic        sec_wrap, min_wrap;

   // Next mod-60 value of each digit pair; shared by the tick path and the manual set path.
   always_comb begin
      sec_wrap  = (sec_l == 4'd9) && (sec_h == 4'd5);
      min_wrap  = (min_l == 4'd9) && (min_h == 4'd5);
      sec_l_nxt = (sec_l == 4'd9) ? 4'd0 : sec_l + 4'd1;
      sec_h_nxt = sec_h;
      if (sec_l == 4'd9) begin
         sec_h_nxt = (sec_h == 4'd5) ? 4'd0 : sec_h + 4'd1;
      end
      min_l_nxt = (min_l == 4'd9) ? 4'd0 : min_l + 4'd1;
      min_h_nxt = min_h;
      if (min_l == 4'd9) begin
         min_h_nxt = (min_h == 4'd5) ? 4'd0 : min_h + 4'd1;
      end
   end

   // Prescaler and digit state: clear beats running, running beats manual set.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         presc      <= '0;
         sec_l      <= '0;
         sec_h      <= '0;
         min_l      <= '0;
         min_h      <= '0;
         sec_tick   <= 1'b0;
         hour_carry <= 1'b0;
      end else if (bus.Clr) begin
         presc      <= '0;
         sec_l      <= '0;
         sec_h      <= '0;
         min_l      <= '0;
         min_h      <= '0;
         sec_tick   <= 1'b0;
         hour_carry <= 1'b0;
      end else if (bus.Run_En) begin
         if (presc == DIV_MAX) begin
            presc      <= '0;
            sec_l      <= sec_l_nxt;
            sec_h      <= sec_h_nxt;
            // Minutes only move when the seconds roll over 59 -> 00.
            if (sec_wrap) begin
               min_l <= min_l_nxt;
               min_h <= min_h_nxt;
            end
            sec_tick   <= 1'b1;
            hour_carry <= sec_wrap && min_wrap;
         end else begin
            presc      <= presc + 26'd1;
            sec_tick   <= 1'b0;
            hour_carry <= 1'b0;
         end
      end else begin
         // Stopped: prescaler phase is held so resuming continues where it left off.
         sec_tick   <= 1'b0;
         hour_carry <= 1'b0;
         if (bus.Inc_Sec) begin
            sec_l <= sec_l_nxt;
            sec_h <= sec_h_nxt;
         end
         if (bus.Inc_Min) begin
            min_l <= min_l_nxt;
            min_h <= min_h_nxt;
         end
      end
   end

   assign bus.SecL       = sec_l;
   assign bus.SecH       = sec_h;
   assign bus.MinL       = min_l;
   assign bus.MinH       = min_h;
   assign bus.Sec_Tick   = sec_tick;
   assign bus.Hour_Carry = hour_carry;

endmodule
